// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS control encodings and fetch-state type for the front end
package mips_pkg;
  localparam logic [1:0] JUMP_SEQ = 2'b00;
  localparam logic [1:0] JUMP_J   = 2'b01;
  localparam logic [1:0] JUMP_JR  = 2'b10;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FUNC_JR  = 6'h08;
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_ISSUE} fetch_state_e;
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC select (jr > j/jal > taken beq > pc+4)
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [25:0] instr_i,
  input  logic [1:0]  jump_i,
  input  logic        br_i,
  input  logic        zero_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] npc_o,
  output logic        misalign_o
);
  logic [31:0] pc4;
  assign pc4 = pc_i + 32'd4;
  always_comb begin
    npc_o = jump_i == JUMP_JR ? {rs_data_i[31:2], 2'b00} :
            jump_i == JUMP_J  ? {pc4[31:28], instr_i, 2'b00} :
            (br_i && zero_i)  ? pc4 + br_offset(instr_i[15:0]) : pc4;
    misalign_o = jump_i == JUMP_JR && rs_data_i[1:0] != 2'b00;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner; one outstanding imem fetch, holds instr for decode, applies resolved control
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              dec_ready,
  input  logic [1:0]        Jump,
  input  logic              Br,
  input  logic              Zero,
  input  logic [31:0]       rs_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] link_addr,
  output logic              align_err
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, npc;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d, align_err_q, align_err_d;
  logic              misalign, fire, capture;
  next_pc_calc u_next_pc (
    .pc_i       (pc_q),
    .instr_i    (instr_q[25:0]),
    .jump_i     (Jump),
    .br_i       (Br),
    .zero_i     (Zero),
    .rs_data_i  (rs_data),
    .npc_o      (npc),
    .misalign_o (misalign)
  );
  // control inputs only matter through fire, so X outside ISSUE&dec_ready never reaches state
  always_comb begin
    fire          = state_q == ST_ISSUE && dec_ready;
    capture       = state_q == ST_WAIT && imem_valid;
    state_d       = state_q == ST_REQ ? ST_WAIT : capture ? ST_ISSUE : fire ? ST_REQ : state_q;
    pc_d          = fire ? npc : pc_q;
    instr_d       = capture ? imem_rdata : instr_q;
    instr_valid_d = capture || (instr_valid_q && !fire);
    align_err_d   = fire && misalign;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      align_err_q   <= align_err_d;
    end
  end
  assign imem_req    = state_q == ST_REQ && !reset;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_q;
  assign link_addr   = pc_q + 32'd4;
  assign align_err   = align_err_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench with an imem model of variable latency
module tb_fetch_sequencer;
  logic        clk = 1'b0, reset, imem_valid, dec_ready, Br, Zero;
  logic [31:0] imem_rdata, rs_data;
  logic [1:0]  Jump;
  logic        imem_req, instr_valid, align_err;
  logic [31:0] imem_addr, instr, pc_out, link_addr;
  int          checks = 0, failures = 0, req_pulses = 0, n_instr = 0;
  logic [31:0] exp_addr_q[$], exp_instr_q[$];
  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .instr      (instr),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .Jump       (Jump),
    .Br         (Br),
    .Zero       (Zero),
    .rs_data    (rs_data),
    .pc_out     (pc_out),
    .link_addr  (link_addr),
    .align_err  (align_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (imem_req === 1'b1) req_pulses <= req_pulses + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk(tag, {31'b0, obs}, {31'b0, exp});
  endtask
  task automatic idle_ctrl;
    dec_ready = 1'b0;
    Jump      = 'x;
    Br        = 'x;
    Zero      = 'x;
    rs_data   = 'x;
  endtask
  task automatic wait_req;
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_b("req_seen", imem_req, 1'b1);
  endtask
  task automatic do_instr(input logic [31:0] word, input int lat, input int stall, input logic spur,
                          input logic [1:0] jmp, input logic br, input logic zr,
                          input logic [31:0] rs, input logic [31:0] exp_next, input logic exp_align);
    logic [31:0] a, w;
    wait_req();
    a = exp_addr_q.pop_front();
    chk("imem_addr", imem_addr, a);
    exp_instr_q.push_back(word);
    imem_valid = spur;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk_b("req_one_pulse", imem_req, 1'b0);
      chk("addr_held", imem_addr, a);
      if (i == 1) chk_b("align_err_one_cycle", align_err, 1'b0);
      imem_valid = (i == lat);
      imem_rdata = (i == lat) ? word : 32'hBAD0_0000 + 32'(i);
    end
    @(negedge clk);
    w = exp_instr_q.pop_front();
    chk_b("instr_valid", instr_valid, 1'b1);
    chk("instr", instr, w);
    chk("pc_out", pc_out, a);
    imem_valid = spur;
    imem_rdata = 32'hFFFF_0000;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_instr", instr, w);
      chk("stall_pc", pc_out, a);
      chk_b("stall_req", imem_req, 1'b0);
    end
    imem_valid = 1'b0;
    dec_ready  = 1'b1;
    Jump       = jmp;
    Br         = br;
    Zero       = zr;
    rs_data    = rs;
    exp_addr_q.push_back(exp_next);
    chk("link_addr", link_addr, a + 32'd4);
    @(negedge clk);
    idle_ctrl();
    chk_b("instr_valid_drop", instr_valid, 1'b0);
    chk_b("align_err", align_err, exp_align);
    n_instr++;
  endtask
  initial begin
    logic [31:0] a;
    reset      = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = '0;
    idle_ctrl();
    repeat (2) @(negedge clk);
    chk_b("rst_req", imem_req, 1'b0);
    chk_b("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk_b("rst_align_err", align_err, 1'b0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_link", link_addr, 32'h4);
    exp_addr_q.push_back(32'h0);
    reset = 1'b0;
    #1;
    do_instr(32'h2008_0005, 1, 0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0000_0004, 1'b0);
    do_instr(32'h0800_0004, 1, 0, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0,   32'h0000_0010, 1'b0);
    do_instr(32'h1000_FFFE, 1, 0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0,   32'h0000_000C, 1'b0);
    do_instr(32'h0800_0004, 2, 1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0,   32'h0000_0010, 1'b0);
    do_instr(32'h1000_FFFE, 1, 0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0,   32'h0000_0014, 1'b0);
    do_instr(32'h03E0_0008, 1, 0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h40,  32'h0000_0040, 1'b0);
    do_instr(32'h0C00_0100, 1, 0, 1'b0, 2'b01, 1'b1, 1'b1, 32'h0,   32'h0000_0400, 1'b0);
    do_instr(32'h03E0_0008, 1, 0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h123, 32'h0000_0120, 1'b1);
    do_instr(32'h03E0_0008, 4, 5, 1'b1, 2'b10, 1'b0, 1'b0, 32'h200, 32'h0000_0200, 1'b0);
    do_instr(32'h03E0_0008, 1, 0, 1'b0, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    do_instr(32'h0000_0020, 1, 0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0000_0000, 1'b0);
    do_instr(32'h03E0_0008, 1, 0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h80,  32'h0000_0080, 1'b0);
    wait_req();
    a = exp_addr_q.pop_front();
    chk("mid_addr", imem_addr, a);
    @(negedge clk);
    chk_b("mid_wait_req", imem_req, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk_b("mid_rst_req", imem_req, 1'b0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_pc", pc_out, 32'h0);
    chk_b("mid_rst_valid", instr_valid, 1'b0);
    reset = 1'b0;
    #1;
    exp_addr_q.push_back(32'h0);
    do_instr(32'h2008_0005, 1, 0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b0);
    chk("req_count", 32'(req_pulses), 32'(n_instr + 1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
